mux_nch_stream: RTL and testbench
=================================

Name: mux_nch_stream

Overview:
- Parametrised successor of the team's fixed-width gate-level mux family.
- Selects one of N channels, each W bits wide, and presents it through a registered output stage with a valid/ready handshake.
- Two modes:
  - Manual: a static channel select.
  - Round-robin: fair scan over channels that have valid data.
- Sits between multiple producer channels and a single downstream consumer.

Parameters:
- N, 16, number of input channels (N >= 2).
- W, 1, data width per channel in bits (W >= 1).
- SW, clog2(N), select/channel-index width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N*W  channel c occupies bits [c*W +: W].
- in_valid  input  N  per-channel data valid.
- in_ready  output  N  per-channel accept strobe; at most one bit high per cycle.
- mode  input  1  0 = manual select, 1 = round-robin.
- sel_in  input  SW  channel index used in manual mode.
- out_data  output  W  registered selected data.
- out_ch  output  SW  index of the channel that produced out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts when out_valid & out_ready.
- sel_err  output  1  registered one-cycle pulse: manual mode with sel_in >= N.

Behaviour:
- Reset and clock:
  - Single clock; reset is synchronous and active-high on rst.
  - Reset values: out_valid=0, out_data=0, out_ch=0, sel_err=0, round-robin pointer=N-1, so channel 0 has first priority.
  - in_ready is combinational and is 0 while rst=1.
- slot_free = !out_valid | out_ready (output register empty, or draining this cycle).
- Grant choice, manual mode:
  - cand = sel_in.
  - grant when slot_free & sel_in < N & in_valid[sel_in].
- Grant choice, round-robin mode:
  - cand = first c with in_valid[c]=1, searching ptr+1, ptr+2, ... modulo N (wraps from N-1 to 0).
  - No grant if no channel is valid.
- On grant:
  - in_ready[cand]=1 in the same cycle.
  - Next edge: out_data <= in_data[cand], out_ch <= cand, out_valid <= 1.
  - In round-robin mode only, ptr <= cand.
- No grant and out_ready & out_valid: out_valid <= 0; out_data and out_ch hold their last values.
- No grant and output stalled (out_valid & !out_ready): all outputs hold; in_ready = 0.
- Latency and throughput:
  - Latency is 1 cycle from accept to out_valid.
  - Sustained throughput is 1 word per cycle when the consumer holds out_ready=1.
- Simultaneous drain and accept in the same cycle: the register is overwritten; out_valid stays 1; no bubble.
- Manual-mode invalid select:
  - sel_in >= N gives no grant and sel_err=1 on the next cycle.
  - sel_err is re-evaluated each cycle; it is never sticky and is always 0 in round-robin mode.
- Mode changes:
  - mode is sampled each cycle.
  - A held output word is unaffected by a mode change.
  - ptr is not modified by manual-mode grants; round-robin resumes from the last round-robin grant.
- Reset mid-operation: a pending output word is discarded and no grant is issued during the reset cycle.
- Data must not change while in_valid=1 and in_ready=0. This is a producer obligation; the block does not check it.
- N not a power of two: indices N..2^SW-1 are never granted; the pointer wraps at N-1, not at 2^SW-1.

Decomposition:
- Package mux_pkg:
  - clog2 function.
  - MODE_MANUAL=1'b0 and MODE_RR=1'b1 constants.
- One sub-module, mux_rr_pick (parameter N):
  - Combinational rotate-priority picker: inputs req[N] and ptr; outputs gnt_idx and gnt_any.
  - Instantiated once; the manual path is handled in the top level.
- Top level holds:
  - The W-bit N:1 data mux as an indexed part-select.
  - The output register, handshake logic and pointer.

Test Plan (N=4, W=8):
- Manual, out_ready=1:
  - Stimulus: sel_in=2, in_valid=4'b0100, ch2=8'hA5.
  - Required: in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_ch=2.
- Round-robin, all valid, out_ready=1:
  - Stimulus: data ch0..3 = 8'h10, 8'h11, 8'h12, 8'h13.
  - Required: outputs 10, 11, 12, 13, 10 on consecutive cycles with out_ch 0, 1, 2, 3, 0 (wrap checked).
- Back-pressure:
  - Stimulus: round-robin, in_valid=4'b1111, out_ready=0 for 3 cycles after the first word.
  - Required: out_data holds 8'h10, in_ready=0 during the stall; after release the next word is ch1 with no bubble.
- Sparse round-robin:
  - Stimulus: in_valid=4'b1001.
  - Required: grants alternate ch0, ch3, ch0; ch1 and ch2 are never granted.
- Invalid select:
  - Stimulus: N=3 build, manual, sel_in=3, in_valid=3'b111.
  - Required: in_ready=0, out_valid stays 0, sel_err=1 one cycle later; sel_err=0 once sel_in=1.
- Reset mid-stream:
  - Stimulus: assert rst with out_valid=1 and out_ready=0.
  - Required: next cycle out_valid=0, out_ch=0; the first round-robin grant after reset goes to ch0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the parametrised N-channel stream mux.
package mux_pkg;

  // Mode encodings for the mux_nch_stream mode input.
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // Ceiling log2, used to size channel-index fields (returns 0 for n <= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Rotate-priority picker: returns the first requesting channel found when
// scanning ptr+1, ptr+2, ... modulo N. Purely combinational.
module mux_rr_pick
  import mux_pkg::*;
#(
  parameter  int N  = 16,
  localparam int SW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_any
);

  int dist_s;
  int best_s;

  // Pick the requester with the smallest rotated distance from ptr+1.
  always_comb begin
    best_s  = N;
    dist_s  = 0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int c = 0; c < N; c++) begin
      // Distance of channel c from the slot just after ptr; ptr is always < N.
      dist_s = c + N - 1 - int'(ptr);
      dist_s = (dist_s >= N) ? (dist_s - N) : dist_s;
      if (req[c] && (dist_s < best_s)) begin
        best_s  = dist_s;
        gnt_idx = SW'(c);
        gnt_any = 1'b1;
      end else begin
        gnt_any = gnt_any;
      end
    end
  end

endmodule

// File: rtl/mux_nch_stream.sv
// N-channel, W-bit stream multiplexer with a registered valid/ready output
// stage. Manual mode forwards the channel named by sel_in; round-robin mode
// scans fairly over valid channels starting after the last round-robin grant.
module mux_nch_stream
  import mux_pkg::*;
#(
  parameter  int N  = 16,
  parameter  int W  = 1,
  localparam int SW = clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel_in,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           sel_err
);

  // N widened by one bit so the range check on sel_in is never out of range.
  localparam logic [SW:0]   N_EXT    = (SW + 1)'(N);
  // Pointer starts at the last channel so channel 0 wins first after reset.
  localparam logic [SW-1:0] PTR_INIT = SW'(N - 1);

  logic [W-1:0]  out_data_r;
  logic [SW-1:0] out_ch_r;
  logic          out_valid_r;
  logic          sel_err_r;
  logic [SW-1:0] ptr_r;

  logic          slot_free_s;
  logic          sel_ok_s;
  logic          man_valid_s;
  logic [SW-1:0] rr_idx_s;
  logic          rr_any_s;
  logic [SW-1:0] cand_s;
  logic          grant_s;
  logic [N-1:0]  in_ready_s;
  logic [W-1:0]  cand_data_s;

  mux_rr_pick #(
    .N (N)
  ) u_rr_pick (
    .req     (in_valid),
    .ptr     (ptr_r),
    .gnt_idx (rr_idx_s),
    .gnt_any (rr_any_s)
  );

  // Candidate selection, grant decision and the one-hot accept strobe.
  always_comb begin
    slot_free_s = !out_valid_r || out_ready;
    sel_ok_s    = ({1'b0, sel_in} < N_EXT);
    if (sel_ok_s) begin
      man_valid_s = in_valid[sel_in];
    end else begin
      man_valid_s = 1'b0;
    end
    if (mode == MODE_RR) begin
      cand_s  = rr_idx_s;
      grant_s = !rst && slot_free_s && rr_any_s;
    end else begin
      cand_s  = sel_in;
      grant_s = !rst && slot_free_s && man_valid_s;
    end
    for (int c = 0; c < N; c++) begin
      in_ready_s[c] = grant_s && (cand_s == SW'(c));
    end
    cand_data_s = in_data[int'(cand_s) * W +: W];
  end

  // Output register, handshake state, round-robin pointer and select error.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r  <= '0;
      out_ch_r    <= '0;
      out_valid_r <= 1'b0;
      sel_err_r   <= 1'b0;
      ptr_r       <= PTR_INIT;
    end else begin
      if (grant_s) begin
        out_data_r  <= cand_data_s;
        out_ch_r    <= cand_s;
        out_valid_r <= 1'b1;
        // Manual grants leave the pointer alone so round-robin resumes in order.
        if (mode == MODE_RR) begin
          ptr_r <= cand_s;
        end else begin
          ptr_r <= ptr_r;
        end
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      sel_err_r <= (mode == MODE_MANUAL) && !sel_ok_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;
  assign out_valid = out_valid_r;
  assign sel_err   = sel_err_r;

endmodule

// File: tb/tb_mux_nch_stream.sv
// Directed self-checking bench for mux_nch_stream: an N=4/W=8 instance for the
// main scenarios and an N=3/W=8 instance for out-of-range select and wrap at N-1.
module tb_mux_nch_stream;

  logic        clk;
  logic        rst;

  logic [31:0] in_data4;
  logic [3:0]  in_valid4;
  logic [3:0]  in_ready4;
  logic        mode4;
  logic [1:0]  sel4;
  logic [7:0]  out_data4;
  logic [1:0]  out_ch4;
  logic        out_valid4;
  logic        out_ready4;
  logic        sel_err4;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic        mode3;
  logic [1:0]  sel3;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;
  logic        out_ready3;
  logic        sel_err3;

  int checks;
  int errors;

  mux_nch_stream #(.N(4), .W(8)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .mode      (mode4),
    .sel_in    (sel4),
    .out_data  (out_data4),
    .out_ch    (out_ch4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sel_err   (sel_err4)
  );

  mux_nch_stream #(.N(3), .W(8)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .mode      (mode3),
    .sel_in    (sel3),
    .out_data  (out_data3),
    .out_ch    (out_ch3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .sel_err   (sel_err3)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it when observed differs from expected.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle synchronous reset of both instances.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Directed scenario sequence.
  initial begin
    int ch;
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    in_data4   = 32'h13121110;
    in_valid4  = 4'b1111;
    mode4      = 1'b1;
    sel4       = 2'd0;
    out_ready4 = 1'b1;
    in_data3   = 24'h222120;
    in_valid3  = 3'b000;
    mode3      = 1'b0;
    sel3       = 2'd0;
    out_ready3 = 1'b1;

    // Reset: no accept while rst is high, all outputs cleared.
    #1;
    check("rst_in_ready", 32'(in_ready4), 32'h0);
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid4), 32'h0);
    check("rst_out_data", 32'(out_data4), 32'h0);
    check("rst_out_ch", 32'(out_ch4), 32'h0);
    check("rst_sel_err", 32'(sel_err4), 32'h0);
    check("rst_out_valid3", 32'(out_valid3), 32'h0);
    rst = 1'b0;

    // Manual select of channel 2.
    mode4     = 1'b0;
    sel4      = 2'd2;
    in_valid4 = 4'b0100;
    in_data4  = 32'h13A51110;
    #1;
    check("man_in_ready", 32'(in_ready4), 32'h4);
    tick();
    check("man_out_valid", 32'(out_valid4), 32'h1);
    check("man_out_data", 32'(out_data4), 32'hA5);
    check("man_out_ch", 32'(out_ch4), 32'h2);
    in_valid4 = 4'b0000;
    #1;
    check("man_idle_ready", 32'(in_ready4), 32'h0);
    tick();
    check("drain_out_valid", 32'(out_valid4), 32'h0);
    check("drain_hold_data", 32'(out_data4), 32'hA5);

    // Round-robin over all channels, including the wrap back to channel 0.
    in_data4  = 32'h13121110;
    mode4     = 1'b1;
    in_valid4 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      ch = k % 4;
      #1;
      check("rr_in_ready", 32'(in_ready4), 32'(1 << ch));
      tick();
      check("rr_out_data", 32'(out_data4), 32'(8'h10 + ch));
      check("rr_out_ch", 32'(out_ch4), 32'(ch));
      check("rr_out_valid", 32'(out_valid4), 32'h1);
    end

    // Back-pressure: first word held for three cycles, then ch1 with no bubble.
    do_reset();
    out_ready4 = 1'b0;
    #1;
    check("bp_first_ready", 32'(in_ready4), 32'h1);
    tick();
    check("bp_first_data", 32'(out_data4), 32'h10);
    for (int s = 0; s < 3; s++) begin
      #1;
      check("bp_stall_ready", 32'(in_ready4), 32'h0);
      tick();
      check("bp_stall_data", 32'(out_data4), 32'h10);
      check("bp_stall_valid", 32'(out_valid4), 32'h1);
      check("bp_stall_ch", 32'(out_ch4), 32'h0);
    end
    out_ready4 = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready4), 32'h2);
    tick();
    check("bp_release_data", 32'(out_data4), 32'h11);
    check("bp_release_ch", 32'(out_ch4), 32'h1);
    check("bp_release_valid", 32'(out_valid4), 32'h1);

    // Sparse round-robin: only ch0 and ch3 request, grants alternate.
    do_reset();
    in_valid4 = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      ch = ((k % 2) == 1) ? 3 : 0;
      #1;
      check("sparse_in_ready", 32'(in_ready4), 32'(1 << ch));
      tick();
      check("sparse_out_ch", 32'(out_ch4), 32'(ch));
      check("sparse_out_data", 32'(out_data4), 32'(8'h10 + ch));
    end

    // Manual grant of ch3 must not move the pointer (last RR grant was ch0).
    mode4 = 1'b0;
    sel4  = 2'd3;
    #1;
    check("mix_man_ready", 32'(in_ready4), 32'h8);
    tick();
    check("mix_man_ch", 32'(out_ch4), 32'h3);
    check("mix_man_sel_err", 32'(sel_err4), 32'h0);
    mode4     = 1'b1;
    in_valid4 = 4'b1111;
    #1;
    check("mix_rr_ready", 32'(in_ready4), 32'h2);
    tick();
    check("mix_rr_ch", 32'(out_ch4), 32'h1);
    check("mix_rr_data", 32'(out_data4), 32'h11);

    // Reset while a word is held under back-pressure.
    out_ready4 = 1'b0;
    tick();
    check("mid_hold_valid", 32'(out_valid4), 32'h1);
    check("mid_hold_ch", 32'(out_ch4), 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(in_ready4), 32'h0);
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid4), 32'h0);
    check("mid_rst_ch", 32'(out_ch4), 32'h0);
    out_ready4 = 1'b1;
    #1;
    check("mid_first_ready", 32'(in_ready4), 32'h1);
    tick();
    check("mid_first_ch", 32'(out_ch4), 32'h0);
    check("mid_first_data", 32'(out_data4), 32'h10);
    in_valid4 = 4'b0000;

    // N=3: out-of-range manual select, then a legal one.
    mode3     = 1'b0;
    sel3      = 2'd3;
    in_valid3 = 3'b111;
    #1;
    check("bad_sel_ready", 32'(in_ready3), 32'h0);
    tick();
    check("bad_sel_err", 32'(sel_err3), 32'h1);
    check("bad_sel_valid", 32'(out_valid3), 32'h0);
    sel3 = 2'd1;
    #1;
    check("good_sel_ready", 32'(in_ready3), 32'h2);
    tick();
    check("good_sel_err", 32'(sel_err3), 32'h0);
    check("good_sel_valid", 32'(out_valid3), 32'h1);
    check("good_sel_ch", 32'(out_ch3), 32'h1);
    check("good_sel_data", 32'(out_data3), 32'h21);

    // N=3 round-robin: pointer wraps at 2; sel_err stays 0 despite sel_in=3.
    mode3 = 1'b1;
    sel3  = 2'd3;
    for (int k = 0; k < 4; k++) begin
      ch = k % 3;
      #1;
      check("rr3_in_ready", 32'(in_ready3), 32'(1 << ch));
      tick();
      check("rr3_out_ch", 32'(out_ch3), 32'(ch));
      check("rr3_out_data", 32'(out_data3), 32'(8'h20 + ch));
      check("rr3_sel_err", 32'(sel_err3), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
